input_skew_buffer: RTL and testbench
====================================

Name: input_skew_buffer

Overview:
- Sits directly downstream of the input router, between its per-row data outputs and the west edge of the systolic PE array.
- Pops one column of ROW_COUNT bytes per cycle from the router using the router's ready / out-enable handshake.
- Delays row r by r extra cycles to form the systolic diagonal wavefront, and inserts zero bubbles whenever no column is popped.
- After the router signals route done, flushes the triangle with zeros and reports done to the top-level controller.

Parameters:
- ROW_COUNT, 4, number of router lanes and array rows.
- DATA_WIDTH, 8, bits per lane element.
- COUNT_WIDTH, 8, width of the popped-column counter.

Ports:
- i_clk  input  1  clock.
- i_nrst  input  1  asynchronous active-low reset.
- i_en  input  1  start; sampled in IDLE only.
- i_reg_clear  input  1  synchronous clear of all state to reset values.
- i_route_ready  input  1  router has column data available (router data-out ready).
- i_rerouting  input  1  router is refilling; no pops allowed.
- i_route_done  input  1  router finished the tile; level or pulse.
- i_data  input  ROW_COUNT*DATA_WIDTH  packed column, lane r = row r.
- i_array_stall  input  1  PE array back-pressure; freezes this block.
- o_route_pop_en  output  1  drives router data-out enable.
- o_data  output  ROW_COUNT*DATA_WIDTH  skewed row data to the array.
- o_valid  output  1  row-0 element on o_data is real data.
- o_busy  output  1  state is STREAM or DRAIN.
- o_done  output  1  one-cycle pulse at the end of drain.
- o_col_count  output  COUNT_WIDTH  columns popped since start.

Behaviour:
- Reset and clear: all outputs 0, skew registers 0, state IDLE. i_reg_clear has the same effect synchronously and wins over every other input.
- advance = ~i_array_stall. When advance = 0, every register and the FSM hold, and o_route_pop_en = 0.
- o_route_pop_en = (state == STREAM) & i_route_ready & ~i_rerouting & advance. This is combinational.
- A pop occurs in any cycle with o_route_pop_en = 1. i_data is valid in that same cycle.
- Skew, lane r: chain of r+1 registers, loaded with i_data[r] on a pop and with 0 on a non-pop advance. o_data[r] is the chain tail.
- Latency: row r element popped in cycle t appears on o_data in cycle t+1+r, counting advancing cycles only.
- o_valid follows the same 1-register path as lane 0; it is 1 exactly when the lane-0 output came from a pop.
- o_col_count increments on each pop and saturates at all-ones. It is cleared on the IDLE->STREAM transition.
- FSM states and transitions:
  - IDLE: i_en -> STREAM.
  - STREAM: i_route_done with no pop in the same cycle -> DRAIN, drain counter = ROW_COUNT. If i_route_done and a pop coincide, the pop is taken and DRAIN is entered on the next advancing cycle.
  - DRAIN: inject zeros; the counter decrements on each advance. At 0, o_done pulses for 1 cycle -> DONE.
  - DONE: -> IDLE on the next cycle.
- A drain of ROW_COUNT advances guarantees the last popped column has fully exited lane ROW_COUNT-1.
- i_rerouting in STREAM: pops are blocked and zero bubbles are inserted; the FSM does not change state.
- i_en outside IDLE is ignored. i_route_done outside STREAM is ignored.
- Asynchronous reset mid-operation: immediate return to reset values. Any in-flight data is discarded with no o_done.

Optional Feature:
- Macro SKEW_ROW_VALID_EN.
- Defined: adds output o_row_valid, width ROW_COUNT. Each bit travels a 1-bit chain matching its lane (r+1 stages). o_valid equals o_row_valid[0].
- Undefined: the port is absent; only o_valid exists. Data timing is identical in both builds.

Test Plan:
- Single column: start, i_route_ready=1, one pop of {8'h04,8'h03,8'h02,8'h01} (lane0=01), then i_route_done -> o_data lane0=01 at t+1, lane1=02 at t+2, lane2=03 at t+3, lane3=04 at t+4. o_done pulses at the end of the ROW_COUNT-cycle drain. o_col_count=1.
- Stream 5 columns, values lane r = 16*c + r -> every lane shows the 5 values in order, offset by r cycles, zeros elsewhere. o_col_count=5.
- i_array_stall high for 3 cycles mid-stream -> o_route_pop_en=0, o_data frozen; the sequence resumes unchanged with no lost or duplicated column.
- i_rerouting high 2 cycles, then low -> two zero bubbles with o_valid=0 appear in every lane at the matching offsets. o_col_count is unaffected.
- i_route_done coincident with the final pop -> the pop is captured, the last column fully exits, and a single o_done pulse occurs.
- i_nrst asserted during DRAIN -> all outputs 0 immediately, no o_done. A restart with i_en streams correctly.

Source files
------------

// File: rtl/input_skew_buffer.sv
// Skews router columns into a systolic diagonal wavefront for the PE array west edge.
// Optional macro SKEW_ROW_VALID_EN adds a per-row valid output (o_row_valid).
module input_skew_buffer #(
  parameter int ROW_COUNT   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_en,
  input  logic                            i_reg_clear,
  input  logic                            i_route_ready,
  input  logic                            i_rerouting,
  input  logic                            i_route_done,
  input  logic [ROW_COUNT*DATA_WIDTH-1:0] i_data,
  input  logic                            i_array_stall,
  output logic                            o_route_pop_en,
  output logic [ROW_COUNT*DATA_WIDTH-1:0] o_data,
`ifdef SKEW_ROW_VALID_EN
  output logic [ROW_COUNT-1:0]            o_row_valid,
`endif
  output logic                            o_valid,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [COUNT_WIDTH-1:0]          o_col_count
);

  localparam int DRAIN_W = $clog2(ROW_COUNT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               done_pend;
  logic               advance;
  logic               pop;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign advance        = ~i_array_stall;
  assign pop            = (state == STREAM) & i_route_ready & ~i_rerouting & advance;
  assign o_route_pop_en = pop;
  assign o_busy         = (state == STREAM) || (state == DRAIN);

  // done_pend remembers a route_done that arrived together with a pop, so a pulse is not lost
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      done_pend   <= 1'b0;
      o_done      <= 1'b0;
      o_col_count <= '0;
    end else if (i_reg_clear) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      done_pend   <= 1'b0;
      o_done      <= 1'b0;
      o_col_count <= '0;
    end else if (advance) begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en) begin
            state       <= STREAM;
            o_col_count <= '0;
          end
        end
        STREAM: begin
          if (pop)
            o_col_count <= sat_inc(o_col_count);
          if (done_pend || (i_route_done && !pop)) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_W'(ROW_COUNT);
            done_pend <= 1'b0;
          end else if (i_route_done) begin
            done_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt <= DRAIN_W'(1)) begin
            drain_cnt <= '0;
            o_done    <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane r: r+1 stage chain, stage 0 loads the popped byte or a zero bubble
  for (genvar r = 0; r < ROW_COUNT; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] chain_p [0:r];
`ifdef SKEW_ROW_VALID_EN
    logic                  vld_p   [0:r];
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        for (int k = 0; k <= r; k++) begin
          chain_p[k] <= '0;
`ifdef SKEW_ROW_VALID_EN
          vld_p[k]   <= 1'b0;
`endif
        end
      end else if (i_reg_clear) begin
        for (int k = 0; k <= r; k++) begin
          chain_p[k] <= '0;
`ifdef SKEW_ROW_VALID_EN
          vld_p[k]   <= 1'b0;
`endif
        end
      end else if (advance) begin
        chain_p[0] <= pop ? i_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef SKEW_ROW_VALID_EN
        vld_p[0]   <= pop;
`endif
        for (int k = 1; k <= r; k++) begin
          chain_p[k] <= chain_p[k-1];
`ifdef SKEW_ROW_VALID_EN
          vld_p[k]   <= vld_p[k-1];
`endif
        end
      end
    end

    assign o_data[r*DATA_WIDTH +: DATA_WIDTH] = chain_p[r];
`ifdef SKEW_ROW_VALID_EN
    assign o_row_valid[r] = vld_p[r];
`endif
  end

`ifdef SKEW_ROW_VALID_EN
  assign o_valid = o_row_valid[0];
`else
  logic vld_p0;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      vld_p0 <= 1'b0;
    else if (i_reg_clear)
      vld_p0 <= 1'b0;
    else if (advance)
      vld_p0 <= pop;
  end

  assign o_valid = vld_p0;
`endif

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer: single column, streams, stall, reroute, coincident done, reset, clear.
module tb_input_skew_buffer;
  localparam int RC = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              nrst, en, clr, ready, rerout, rdone, stall;
  logic [RC*DW-1:0]  din;
  logic              pop_en, valid, busy, done;
  logic [RC*DW-1:0]  dout;
  logic [CW-1:0]     cnt;
`ifdef SKEW_ROW_VALID_EN
  logic [RC-1:0]     row_valid;
`endif

  input_skew_buffer #(.ROW_COUNT(RC), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_reg_clear(clr),
    .i_route_ready(ready), .i_rerouting(rerout), .i_route_done(rdone),
    .i_data(din), .i_array_stall(stall), .o_route_pop_en(pop_en), .o_data(dout),
`ifdef SKEW_ROW_VALID_EN
    .o_row_valid(row_valid),
`endif
    .o_valid(valid), .o_busy(busy), .o_done(done), .o_col_count(cnt)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] hist_d [$];
  bit          hist_v [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    logic [31:0] e;
    e = '0;
    for (int r = 0; r < RC; r++)
      if (r < hist_d.size()) e[r*DW +: DW] = hist_d[r][r*DW +: DW];
    return e;
  endfunction

  function automatic logic [31:0] col(input int c);
    logic [31:0] d;
    for (int r = 0; r < RC; r++) d[r*DW +: DW] = 8'(16 * c + r);
    return d;
  endfunction

  // One clock: check registered outputs, drive inputs, check pop enable, update the history
  task automatic cycle(input string tag, input bit e, input bit rdy, input bit rr, input bit st,
                       input logic [31:0] d, input bit dn, input bit exp_pop);
    @(negedge clk);
    chk({tag, " data"}, dout, exp_data());
    chk({tag, " valid"}, {31'b0, valid}, {31'b0, (hist_v.size() > 0) ? hist_v[0] : 1'b0});
`ifdef SKEW_ROW_VALID_EN
    for (int r = 0; r < RC; r++)
      chk({tag, " row_valid"}, {31'b0, row_valid[r]}, {31'b0, (r < hist_v.size()) ? hist_v[r] : 1'b0});
`endif
    en = e; ready = rdy; rerout = rr; stall = st; din = d; rdone = dn;
    #1;
    chk({tag, " pop_en"}, {31'b0, pop_en}, {31'b0, exp_pop});
    if (!st) begin
      hist_d.push_front(exp_pop ? d : 32'h0);
      hist_v.push_front(exp_pop);
      if (hist_d.size() > RC) begin
        void'(hist_d.pop_back());
        void'(hist_v.pop_back());
      end
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic start(input string tag);
    cycle(tag, 1, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic drain(input string tag, input logic [31:0] exp_cnt);
    for (int i = 0; i < RC; i++) begin
      idle(tag);
      chk({tag, " drain busy"}, {31'b0, busy}, 32'd1);
      chk({tag, " drain done"}, {31'b0, done}, 32'd0);
    end
    idle(tag);
    chk({tag, " done pulse"}, {31'b0, done}, 32'd1);
    chk({tag, " done busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " col_count"}, {24'b0, cnt}, exp_cnt);
    idle(tag);
    chk({tag, " done end"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; en = 0; clr = 0; ready = 0; rerout = 0; rdone = 0; stall = 0; din = '0;
    repeat (2) @(negedge clk);
    chk("reset data", dout, 32'h0);
    chk("reset valid", {31'b0, valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset count", {24'b0, cnt}, 32'd0);
    chk("reset pop_en", {31'b0, pop_en}, 32'd0);
    nrst = 1'b1;

    // Single column: lane r shows byte r+1 r cycles after lane 0
    start("t1 start");
    cycle("t1 pop", 0, 1, 0, 0, 32'h04030201, 0, 1);
    chk("t1 busy", {31'b0, busy}, 32'd1);
    cycle("t1 rdone", 0, 0, 0, 0, 32'h0, 1, 0);
    chk("t1 lane0", dout, 32'h00000001);
    idle("t1 d1");
    chk("t1 lane1", dout, 32'h00000200);
    idle("t1 d2");
    chk("t1 lane2", dout, 32'h00030000);
    idle("t1 d3");
    chk("t1 lane3", dout, 32'h04000000);
    idle("t1 d4");
    idle("t1 d5");
    chk("t1 done", {31'b0, done}, 32'd1);
    chk("t1 count", {24'b0, cnt}, 32'd1);
    idle("t1 idle");
    cycle("t1 ignore ready", 0, 1, 0, 0, 32'hffffffff, 0, 0);

    // Five back-to-back columns
    start("A start");
    for (int c = 0; c < 5; c++) cycle("A pop", 0, 1, 0, 0, col(c), 0, 1);
    cycle("A rdone", 0, 0, 0, 0, 32'h0, 1, 0);
    drain("A", 32'd5);

    // Stall and reroute mid-stream, route_done coincident with the last pop
    start("B start");
    cycle("B pop0", 0, 1, 0, 0, col(8), 0, 1);
    cycle("B pop1", 0, 1, 0, 0, col(9), 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle("B stall", 0, 1, 0, 1, col(15), 1, 0);
      chk("B stall busy", {31'b0, busy}, 32'd1);
    end
    cycle("B pop2", 0, 1, 0, 0, col(10), 0, 1);
    cycle("B pop3", 0, 1, 0, 0, col(11), 0, 1);
    for (int i = 0; i < 2; i++) cycle("B reroute", 0, 1, 1, 0, col(15), 0, 0);
    chk("B count after reroute", {24'b0, cnt}, 32'd4);
    cycle("B pop4 rdone", 0, 1, 0, 0, col(12), 1, 1);
    cycle("B pend", 0, 0, 0, 0, 32'h0, 0, 0);
    drain("B", 32'd5);

    // Column counter saturation
    start("D start");
    for (int c = 0; c < 260; c++) cycle("D pop", 0, 1, 0, 0, col(c % 16), 0, 1);
    cycle("D rdone", 0, 0, 0, 0, 32'h0, 1, 0);
    drain("D", 32'd255);

    // Asynchronous reset during drain, then restart
    start("C start");
    cycle("C pop0", 0, 1, 0, 0, col(13), 0, 1);
    cycle("C pop1", 0, 1, 0, 0, col(14), 0, 1);
    cycle("C rdone", 0, 0, 0, 0, 32'h0, 1, 0);
    idle("C d1");
    idle("C d2");
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("C rst data", dout, 32'h0);
    chk("C rst valid", {31'b0, valid}, 32'd0);
    chk("C rst busy", {31'b0, busy}, 32'd0);
    chk("C rst done", {31'b0, done}, 32'd0);
    chk("C rst count", {24'b0, cnt}, 32'd0);
    hist_d.delete();
    hist_v.delete();
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle("C post");
      chk("C post done", {31'b0, done}, 32'd0);
      chk("C post busy", {31'b0, busy}, 32'd0);
    end
    start("C restart");
    cycle("C pop2", 0, 1, 0, 0, 32'h8d7c6b5a, 0, 1);
    cycle("C rdone2", 0, 0, 0, 0, 32'h0, 1, 0);
    drain("C", 32'd1);

    // Synchronous clear mid-stream
    start("E start");
    cycle("E pop", 0, 1, 0, 0, col(7), 0, 1);
    @(negedge clk);
    clr = 1'b1; ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    hist_d.delete();
    hist_v.delete();
    chk("E clr data", dout, 32'h0);
    chk("E clr busy", {31'b0, busy}, 32'd0);
    chk("E clr count", {24'b0, cnt}, 32'd0);
    cycle("E idle", 0, 1, 0, 0, col(3), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
